// File: rtl/mul8_error_monitor_if.sv
// rtl/mul8_error_monitor_if.sv - sample and per-sample result channel of the 8x8 multiplier error monitor
interface mul8_error_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] result;
    logic        exact_valid;
    logic [15:0] exact;
    logic        mismatch;
    logic [15:0] abs_err;

    modport master (
        output in_valid, a, b, result,
        input  in_ready, exact_valid, exact, mismatch, abs_err
    );

    modport slave (
        input  in_valid, a, b, result,
        output in_ready, exact_valid, exact, mismatch, abs_err
    );
endinterface

// File: rtl/mul8_error_monitor.sv
// rtl/mul8_error_monitor.sv - shift-add reference multiplier that scores a multiplier under test
module mul8_error_monitor #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    mul8_error_monitor_if.slave  mon,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic [15:0]          max_abs_err,
    output logic [SUM_W-1:0]     sum_abs_err
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         iter_q, iter_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [15:0]        res_q, res_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        exact_q, exact_d;
    logic [15:0]        abs_err_q, abs_err_d;
    logic               mismatch_q, mismatch_d;
    logic [CNT_W-1:0]   sample_count_q, sample_count_d;
    logic [CNT_W-1:0]   mismatch_count_q, mismatch_count_d;
    logic [15:0]        max_abs_err_q, max_abs_err_d;
    logic [SUM_W-1:0]   sum_abs_err_q, sum_abs_err_d;

    logic [15:0]        partial;
    logic [15:0]        acc_sum;
    logic [16:0]        diff;
    logic [15:0]        mag;
    logic [SUM_W:0]     sum_ext;

    always_comb begin
        state_d          = state_q;
        iter_d           = iter_q;
        a_d              = a_q;
        b_d              = b_q;
        res_d            = res_q;
        acc_d            = acc_q;
        exact_d          = exact_q;
        abs_err_d        = abs_err_q;
        mismatch_d       = mismatch_q;
        sample_count_d   = sample_count_q;
        mismatch_count_d = mismatch_count_q;
        max_abs_err_d    = max_abs_err_q;
        sum_abs_err_d    = sum_abs_err_q;

        partial = b_q[iter_q] ? ({8'd0, a_q} << iter_q) : 16'd0;
        acc_sum = acc_q + partial;
        // Error is taken against the final product on the last MUL edge, so it is ready in DONE.
        diff    = {1'b0, res_q} - {1'b0, acc_sum};
        mag     = diff[16] ? (16'd0 - diff[15:0]) : diff[15:0];
        sum_ext = {1'b0, sum_abs_err_q} + (SUM_W+1)'(abs_err_q);

        case (state_q)
            IDLE: begin
                if (mon.in_valid) begin
                    a_d     = mon.a;
                    b_d     = mon.b;
                    res_d   = mon.result;
                    acc_d   = 16'd0;
                    iter_d  = 3'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_sum;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    exact_d    = acc_sum;
                    abs_err_d  = mag;
                    mismatch_d = (mag != 16'd0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!(&sample_count_q))
                    sample_count_d = sample_count_q + CNT_W'(1);
                if (mismatch_q && !(&mismatch_count_q))
                    mismatch_count_d = mismatch_count_q + CNT_W'(1);
                sum_abs_err_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
                if (abs_err_q > max_abs_err_q)
                    max_abs_err_d = abs_err_q;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides any same-edge statistics update but leaves the sample in flight.
        if (clear) begin
            sample_count_d   = '0;
            mismatch_count_d = '0;
            max_abs_err_d    = 16'd0;
            sum_abs_err_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            iter_q           <= 3'd0;
            a_q              <= 8'd0;
            b_q              <= 8'd0;
            res_q            <= 16'd0;
            acc_q            <= 16'd0;
            exact_q          <= 16'd0;
            abs_err_q        <= 16'd0;
            mismatch_q       <= 1'b0;
            sample_count_q   <= '0;
            mismatch_count_q <= '0;
            max_abs_err_q    <= 16'd0;
            sum_abs_err_q    <= '0;
        end else begin
            state_q          <= state_d;
            iter_q           <= iter_d;
            a_q              <= a_d;
            b_q              <= b_d;
            res_q            <= res_d;
            acc_q            <= acc_d;
            exact_q          <= exact_d;
            abs_err_q        <= abs_err_d;
            mismatch_q       <= mismatch_d;
            sample_count_q   <= sample_count_d;
            mismatch_count_q <= mismatch_count_d;
            max_abs_err_q    <= max_abs_err_d;
            sum_abs_err_q    <= sum_abs_err_d;
        end
    end

    assign mon.in_ready    = (state_q == IDLE);
    assign mon.exact_valid = (state_q == DONE);
    assign mon.exact       = exact_q;
    assign mon.abs_err     = abs_err_q;
    assign mon.mismatch    = mismatch_q;

    assign sample_count   = sample_count_q;
    assign mismatch_count = mismatch_count_q;
    assign max_abs_err    = max_abs_err_q;
    assign sum_abs_err    = sum_abs_err_q;

endmodule

// File: tb/tb_mul8_error_monitor.sv
// tb/tb_mul8_error_monitor.sv - scoreboard bench for mul8_error_monitor
module tb_mul8_error_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    mul8_error_monitor_if mif();

    logic [15:0] sample_count, mismatch_count, max_abs_err;
    logic [23:0] sum_abs_err;

    mul8_error_monitor #(.CNT_W(16), .SUM_W(24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .mon            (mif),
        .sample_count   (sample_count),
        .mismatch_count (mismatch_count),
        .max_abs_err    (max_abs_err),
        .sum_abs_err    (sum_abs_err)
    );

    typedef struct {
        int exact; int err; int mm; int cnt; int mmc; int mx; int sum; int acc;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"}, int'(mif.in_ready), 1);
        chk({tag, "_exact_valid"}, int'(mif.exact_valid), 0);
        chk({tag, "_exact"}, int'(mif.exact), 0);
        chk({tag, "_abs_err"}, int'(mif.abs_err), 0);
        chk({tag, "_mismatch"}, int'(mif.mismatch), 0);
        chk({tag, "_sample_count"}, int'(sample_count), 0);
        chk({tag, "_mismatch_count"}, int'(mismatch_count), 0);
        chk({tag, "_max_abs_err"}, int'(max_abs_err), 0);
        chk({tag, "_sum_abs_err"}, int'(sum_abs_err), 0);
    endtask

    // Monitor: per-sample outputs in the DONE cycle, statistics one cycle later.
    initial begin
        exp_t e;
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("sample_count", int'(sample_count), e.cnt);
                chk("mismatch_count", int'(mismatch_count), e.mmc);
                chk("max_abs_err", int'(max_abs_err), e.mx);
                chk("sum_abs_err", int'(sum_abs_err), e.sum);
                chk("exact_valid_one_cycle", int'(mif.exact_valid), 0);
                pend = 1'b0;
            end else if (mif.exact_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_exact_valid", int'(mif.exact_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("exact", int'(mif.exact), e.exact);
                    chk("abs_err", int'(mif.abs_err), e.err);
                    chk("mismatch", int'(mif.mismatch), e.mm);
                    chk("latency_edges", cyc - e.acc, 8);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] rv,
                        input int ex, input int er, input int mm, input int cn,
                        input int mc, input int mx, input int sm, input bit push);
        int w;
        exp_t e;
        @(negedge clk);
        mif.a = av;
        mif.b = bv;
        mif.result = rv;
        mif.in_valid = 1'b1;
        w = 0;
        while (!mif.in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (w >= 30) chk("ready_timeout", int'(mif.in_ready), 1);
        @(negedge clk);
        mif.in_valid = 1'b0;
        e = '{ex, er, mm, cn, mc, mx, sm, cyc};
        if (push) q.push_back(e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int low;
        int accs[$];
        exp_t e;

        mif.in_valid = 1'b0;
        mif.a = 8'd0;
        mif.b = 8'd0;
        mif.result = 16'd0;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;

        send(8'd255, 8'd255, 16'd65025, 65025, 0, 0, 1, 0, 0, 0, 1'b1);
        send(8'd23, 8'd67, 16'd1500, 1541, 41, 1, 2, 1, 41, 41, 1'b1);
        send(8'd17, 8'd17, 16'd300, 289, 11, 1, 3, 2, 41, 52, 1'b1);
        send(8'd0, 8'd19, 16'd0, 0, 0, 0, 4, 2, 41, 52, 1'b1);
        send(8'd19, 8'd0, 16'd5, 0, 5, 1, 5, 3, 41, 57, 1'b1);

        // Clear during DONE discards that sample's statistics update.
        send(8'd10, 8'd10, 16'd100, 100, 0, 0, 0, 0, 0, 0, 1'b1);
        w = 0;
        while (!mif.exact_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("done_timeout", int'(mif.exact_valid), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drain();

        low = 0;
        mif.a = 8'd3;
        mif.b = 8'd5;
        mif.result = 16'd15;
        mif.in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (mif.in_ready) begin
                accs.push_back(cyc + 1);
                e = '{15, 0, 0, accs.size(), 0, 0, 0, cyc + 1};
                q.push_back(e);
            end else begin
                low++;
            end
            @(negedge clk);
        end
        mif.in_valid = 1'b0;
        chk("hold_accepts", accs.size(), 3);
        if (accs.size() >= 3) begin
            chk("hold_gap_1", accs[1] - accs[0], 10);
            chk("hold_gap_2", accs[2] - accs[1], 10);
        end
        chk("hold_ready_low_cycles", low, 27);
        drain();

        // Abort during the 4th MUL cycle, then accept on the first edge after release.
        send(8'd200, 8'd100, 16'd0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_mul_reset");
        @(negedge clk);
        rst_n = 1'b1;
        mif.a = 8'd200;
        mif.b = 8'd150;
        mif.result = 16'd30500;
        mif.in_valid = 1'b1;
        @(negedge clk);
        chk("accept_after_reset", int'(mif.in_ready), 0);
        mif.in_valid = 1'b0;
        e = '{30000, 500, 1, 1, 1, 500, 500, cyc};
        q.push_back(e);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul8_error_monitor.md
MUL8_ERROR_MONITOR -- requirements
Module: mul8_error_monitor

Interface
REQ-001 Parameter: CNT_W, default 16, width of sample_count and mismatch_count.
REQ-002 Parameter: SUM_W, default 24, width of sum_abs_err.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  sample (a, b, result) presented.
REQ-006 in_ready  output  1  monitor can accept a sample this cycle.
REQ-007 a  input  8  multiplier operand A, unsigned.
REQ-008 b  input  8  multiplier operand B, unsigned.
REQ-009 result  input  16  product reported by the multiplier under test, unsigned.
REQ-010 clear  input  1  synchronous clear of the statistics registers.
REQ-011 exact  output  16  exact product a*b of the last completed sample.
REQ-012 exact_valid  output  1  one-cycle pulse: exact, abs_err and mismatch are valid.
REQ-013 mismatch  output  1  result differed from exact for the last completed sample.
REQ-014 abs_err  output  16  |result - exact| of the last completed sample.
REQ-015 sample_count  output  CNT_W  samples completed since reset or clear.
REQ-016 mismatch_count  output  CNT_W  completed samples with mismatch.
REQ-017 max_abs_err  output  16  largest abs_err since reset or clear.
REQ-018 sum_abs_err  output  SUM_W  sum of abs_err since reset or clear.

Function
REQ-019 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-020 in_ready SHALL be high only in IDLE.
REQ-021 A sample SHALL be accepted on a rising edge where in_valid and in_ready are both high.
- a, b and result are latched on that edge.
- The FSM goes IDLE->MUL and the iteration counter is set to 0.
REQ-022 In MUL, the block SHALL compute exact by unsigned shift-add, one multiplier bit per cycle, for exactly 8 cycles.
- The accumulator is 16 bits wide and never overflows (max 255*255 = 65025).
REQ-023 After the 8th MUL edge, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-024 During the DONE cycle, the outputs SHALL be:
- exact_valid = 1.
- exact holds the exact product.
- abs_err = |result - exact|, computed in 17-bit signed arithmetic, magnitude in 16 bits.
- mismatch = (abs_err != 0).
REQ-025 exact, abs_err and mismatch SHALL hold their values until the next DONE.
REQ-026 Latency: accept at edge k, DONE in cycle after edge k+8, in_ready high again after edge k+9; maximum throughput one sample per 10 cycles.
REQ-027 On the DONE->IDLE edge, the statistics SHALL update as follows:
- sample_count +1.
- mismatch_count +1 if mismatch.
- sum_abs_err += abs_err.
- max_abs_err = abs_err if abs_err > max_abs_err.
REQ-028 sample_count, mismatch_count and sum_abs_err SHALL saturate at all-ones and never wrap.
REQ-029 clear SHALL zero the four statistics registers on the next edge in any state, without aborting an in-flight sample.
- If clear coincides with a statistics update, clear wins and the update is discarded.
REQ-030 A zero operand SHALL give exact = 0; result = 0 then gives no mismatch, and result != 0 gives a mismatch with abs_err = result.
REQ-031 in_valid while in_ready is low SHALL be ignored, with no queuing.

Reset
REQ-032 While rst_n is low, every output SHALL be 0 except in_ready = 1, and the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-MUL or in DONE SHALL abort the sample with no statistics update and no exact_valid pulse.
REQ-034 The first accept after reset SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-035 a=255, b=255, result=65025 -> DONE 9 cycles after accept; exact=65025, mismatch=0, sample_count=1, max_abs_err=0.
REQ-036 Then a=23, b=67, result=1500 -> exact=1541, abs_err=41, mismatch=1, mismatch_count=1, max_abs_err=41, sum_abs_err=41.
REQ-037 Then a=17, b=17, result=300 -> exact=289, abs_err=11, max_abs_err stays 41, sum_abs_err=52, sample_count=3.
REQ-038 Then a=0, b=19, result=0 -> exact=0, mismatch=0, mismatch_count unchanged.
- Then a=19, b=0, result=5 -> mismatch=1, abs_err=5.
REQ-039 Hold in_valid high for 30 cycles -> exactly 3 accepts, 10 cycles apart; in_ready low for 9 cycles after each accept.
REQ-040 Reset and clear:
- rst_n pulsed low during the 4th MUL cycle -> all outputs 0, in_ready=1, no exact_valid pulse.
- clear in the DONE cycle -> all statistics read 0 in the cycle after.
